mac_operand_sequencer: RTL
==========================

# mac_operand_sequencer

Parametrised operand-entry and streaming controller for the FP MAC datapath. It replaces the fixed 8-entry, 16-bit keypad/SRAM sequencer. Operands arrive from the keypad scanner and are stored in two internal banks, A and B. The operand pairs are then streamed to the MAC unit over a valid/ready handshake, and the MAC result is captured for the 7-segment display. Phase and index are exported as a status code for the Arduino link.

## Interface
- DATA_W, 16, operand and result width; FP16 bit pattern.
- DEPTH, 8, operand pairs per run; must be ≥2.
- ADDR_W, 3, index width; must equal clog2(DEPTH).
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- step_n  in  1  raw next-step button, active-low, asynchronous to clk; debounce is external.
- key_valid  in  1  one-cycle strobe: key_data holds a completed entry.
- key_data  in  DATA_W  entered operand.
- mac_a  out  DATA_W  A operand of current pair.
- mac_b  out  DATA_W  B operand of current pair.
- mac_valid  out  1  pair valid.
- mac_last  out  1  current pair is index DEPTH-1.
- mac_ready  in  1  MAC accepts pair.
- res_valid  in  1  one-cycle strobe: res_data holds the final accumulated result.
- res_data  in  DATA_W  MAC result.
- disp_data  out  DATA_W  value for the four hex digits.
- disp_blank  out  1  blank all digits.
- state_code  out  3+ADDR_W  {phase[2:0], idx[ADDR_W-1:0]}.
- busy  out  1  high in STREAM and WAIT_RES.

## Operation
- Phase encodings: IDLE=0, LOAD_A=1, LOAD_B=2, REVIEW=3, STREAM=4, WAIT_RES=5, SHOW=6.
- Reset values:
  - Phase is IDLE and idx is 0.
  - Both banks are all-zero and the result register is 0.
  - All outputs are 0, except disp_blank=1.
- step_n handling: step_n passes through a 2-FF synchroniser, then a falling-edge detector that produces step_p for one cycle. A held button produces exactly one step_p.
- IDLE: display blank. step_p moves to LOAD_A with idx=0.
- LOAD_A and LOAD_B:
  - key_valid writes key_data to bank[idx].
  - disp_data = bank[idx], with disp_blank=0.
  - step_p increments idx. Slots never written keep their previous contents.
  - On step_p at idx=DEPTH-1, idx returns to 0. LOAD_A goes to LOAD_B. LOAD_B goes to REVIEW if MAC_SEQ_REVIEW_EN is defined, otherwise to STREAM.
  - If key_valid and step_p occur in the same cycle, the write goes to the old idx, then idx advances.
- REVIEW: read-only walk through the stored operands. disp_data = A[idx]. step_p advances idx. step_p at DEPTH-1 goes to STREAM with idx=0.
- STREAM:
  - Outputs are mac_a=A[idx], mac_b=B[idx], mac_valid=1, mac_last=(idx==DEPTH-1).
  - A transfer occurs when mac_valid and mac_ready are both high on a clk edge; idx then increments.
  - The transfer at DEPTH-1 goes to WAIT_RES with mac_valid=0.
  - While mac_ready=0, the outputs hold stable.
  - disp_data shows A[idx].
- WAIT_RES: res_valid captures res_data and moves to SHOW.
- SHOW: disp_data = result register. step_p moves to IDLE; banks are retained.
- Ignored events:
  - step_p in STREAM or WAIT_RES.
  - key_valid outside LOAD_A and LOAD_B.
  - res_valid outside WAIT_RES.
- Reset asserted mid-run: immediate return to the reset values, including clearing both banks. No partial handshake is completed.

## Timing
- A step_n falling edge produces step_p 3 clk edges after it is first sampled low. The phase and idx update on the edge where step_p=1.
- Bank write takes effect on the key_valid edge. disp_data shows the new value in the following cycle.
- All outputs are registered or decoded from registered state. There are no combinational paths from input to output.
- Entering STREAM: mac_valid rises the cycle after the transition.
- Throughput with mac_ready held high: one pair per cycle, DEPTH cycles total.
- The result appears on disp_data one cycle after the res_valid edge.

## Configuration
- MAC_SEQ_REVIEW_EN defined: the REVIEW phase is present as described above.
- MAC_SEQ_REVIEW_EN undefined:
  - step_p at LOAD_B idx=DEPTH-1 goes directly to STREAM.
  - Phase code 3 never appears.
  - The REVIEW logic is not synthesised.

## Test plan
- Reset check: release reset and hold for 10 cycles → state_code=0, disp_blank=1, mac_valid=0, busy=0.
- Load and stream (DEPTH=8, mac_ready=1):
  - Stimulus: load A[i]=0x3C00+i and B[i]=0x4000+i, then step through.
  - Required: 8 consecutive transfers with correct pairs. mac_last is high only on pair 7 (0x3C07, 0x4007). busy is high during the stream.
- Backpressure: toggle mac_ready every cycle → each pair is held stable while ready=0. Exactly 8 transfers, in order, with none dropped or duplicated.
- Result path:
  - Stimulus: in WAIT_RES, res_valid with res_data=0x4A80; then a stray res_valid while in SHOW.
  - Required: disp_data=0x4A80 one cycle after the first strobe, and still 0x4A80 after the stray strobe.
- Boundary events:
  - key_valid and step_p in the same cycle at LOAD_A idx=7 → A[7] is written and the phase goes to LOAD_B with idx=0.
  - Button held low for 100 cycles → exactly one advance.
- Mid-run reset and configuration coverage:
  - Assert rst during STREAM at idx=4 → mac_valid drops immediately and the banks read 0 afterwards.
  - Run the suite with the macro defined: phase 3 appears and walks A[0..7].
  - Run the suite with the macro undefined: phase 3 never appears.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mac_operand_sequencer
// Description : Operand-entry and streaming controller for the FP MAC datapath.
//               Keypad entries fill two operand banks (A and B). The stored
//               pairs are then streamed to the MAC over a valid/ready
//               handshake, and the MAC result is captured for the 7-segment
//               display.
// Revision    : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
// Parameters  : DATA_W - operand/result width (FP16 bit pattern)
//               DEPTH  - operand pairs per run (>= 2)
//               ADDR_W - index width, equal to clog2(DEPTH)
// Ports       : clk, rst (async, active-low)
//               step_n              - raw next-step button, active-low
//               key_valid/key_data  - completed keypad entry strobe
//               mac_a/mac_b/mac_valid/mac_last, mac_ready - MAC pair stream
//               res_valid/res_data  - final accumulated MAC result strobe
//               disp_data/disp_blank- 4-digit hex display value / blanking
//               state_code          - {phase[2:0], idx}
//               busy                - high while streaming or awaiting result
// Build macro : MAC_SEQ_REVIEW_EN - adds the read-only REVIEW phase between
//               LOAD_B and STREAM. Undefined: LOAD_B goes straight to STREAM.
// ============================================================================
module mac_operand_sequencer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_n,
  input  logic                  key_valid,
  input  logic [DATA_W-1:0]     key_data,
  output logic [DATA_W-1:0]     mac_a,
  output logic [DATA_W-1:0]     mac_b,
  output logic                  mac_valid,
  output logic                  mac_last,
  input  logic                  mac_ready,
  input  logic                  res_valid,
  input  logic [DATA_W-1:0]     res_data,
  output logic [DATA_W-1:0]     disp_data,
  output logic                  disp_blank,
  output logic [3+ADDR_W-1:0]   state_code,
  output logic                  busy
);

  typedef enum logic [2:0] {
    P_IDLE     = 3'd0,
    P_LOAD_A   = 3'd1,
    P_LOAD_B   = 3'd2,
    P_REVIEW   = 3'd3,
    P_STREAM   = 3'd4,
    P_WAIT_RES = 3'd5,
    P_SHOW     = 3'd6
  } phase_t;

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_idx_one  = ADDR_W'(1);

  phase_t              r_phase;
  logic [ADDR_W-1:0]   r_idx;
  logic [DATA_W-1:0]   r_bank_a [DEPTH];
  logic [DATA_W-1:0]   r_bank_b [DEPTH];
  logic [DATA_W-1:0]   r_result;

  logic                r_step_s1;
  logic                r_step_s2;
  logic                r_step_d;

  logic                w_step_p;
  logic                w_idx_last;

  // --------------------------------------------------------------------------
  // Button synchroniser and falling-edge detector. The chain resets to the
  // released level (1) so that leaving reset never fakes a press.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_s1 <= 1'b1;
      r_step_s2 <= 1'b1;
      r_step_d  <= 1'b1;
    end else begin
      r_step_s1 <= step_n;
      r_step_s2 <= r_step_s1;
      r_step_d  <= r_step_s2;
    end
  end

  assign w_step_p   = r_step_d & ~r_step_s2;
  assign w_idx_last = (r_idx == c_last_idx);

  // --------------------------------------------------------------------------
  // Phase/index controller, operand banks and result register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase  <= P_IDLE;
      r_idx    <= '0;
      r_result <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_bank_a[i] <= '0;
        r_bank_b[i] <= '0;
      end
    end else begin
      case (r_phase)
        P_IDLE: begin
          if (w_step_p) begin
            r_phase <= P_LOAD_A;
            r_idx   <= '0;
          end
        end

        P_LOAD_A: begin
          // Write uses the current idx even when a step lands in the same cycle.
          if (key_valid) r_bank_a[r_idx] <= key_data;
          if (w_step_p) begin
            if (w_idx_last) begin
              r_idx   <= '0;
              r_phase <= P_LOAD_B;
            end else begin
              r_idx <= r_idx + c_idx_one;
            end
          end
        end

        P_LOAD_B: begin
          if (key_valid) r_bank_b[r_idx] <= key_data;
          if (w_step_p) begin
            if (w_idx_last) begin
              r_idx <= '0;
`ifdef MAC_SEQ_REVIEW_EN
              r_phase <= P_REVIEW;
`else
              r_phase <= P_STREAM;
`endif
            end else begin
              r_idx <= r_idx + c_idx_one;
            end
          end
        end

`ifdef MAC_SEQ_REVIEW_EN
        P_REVIEW: begin
          if (w_step_p) begin
            if (w_idx_last) begin
              r_idx   <= '0;
              r_phase <= P_STREAM;
            end else begin
              r_idx <= r_idx + c_idx_one;
            end
          end
        end
`endif

        P_STREAM: begin
          // mac_valid is always high here, so ready alone marks a transfer.
          if (mac_ready) begin
            if (w_idx_last) begin
              r_idx   <= '0;
              r_phase <= P_WAIT_RES;
            end else begin
              r_idx <= r_idx + c_idx_one;
            end
          end
        end

        P_WAIT_RES: begin
          if (res_valid) begin
            r_result <= res_data;
            r_phase  <= P_SHOW;
          end
        end

        P_SHOW: begin
          if (w_step_p) begin
            r_phase <= P_IDLE;
            r_idx   <= '0;
          end
        end

        default: begin
          r_phase <= P_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded purely from registered state.
  // --------------------------------------------------------------------------
  always_comb begin
    mac_valid  = 1'b0;
    mac_last   = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    disp_data  = '0;
    disp_blank = 1'b1;
    busy       = 1'b0;

    case (r_phase)
      P_LOAD_A: begin
        disp_data  = r_bank_a[r_idx];
        disp_blank = 1'b0;
      end
      P_LOAD_B: begin
        disp_data  = r_bank_b[r_idx];
        disp_blank = 1'b0;
      end
`ifdef MAC_SEQ_REVIEW_EN
      P_REVIEW: begin
        disp_data  = r_bank_a[r_idx];
        disp_blank = 1'b0;
      end
`endif
      P_STREAM: begin
        mac_valid  = 1'b1;
        mac_last   = w_idx_last;
        mac_a      = r_bank_a[r_idx];
        mac_b      = r_bank_b[r_idx];
        disp_data  = r_bank_a[r_idx];
        disp_blank = 1'b0;
        busy       = 1'b1;
      end
      P_WAIT_RES: begin
        busy = 1'b1;
      end
      P_SHOW: begin
        disp_data  = r_result;
        disp_blank = 1'b0;
      end
      default: begin
        disp_blank = 1'b1;
      end
    endcase
  end

  assign state_code = {r_phase, r_idx};

endmodule
`default_nettype wire
